divider: RTL and testbench

//   Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/divider_if.sv | 25 ++
 rtl/divider.sv | 103 ++++++++++
 tb/tb_divider.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Request/result bundle for the sequential divider.
// The master drives the start request and operands; the slave (the divider)
// returns the registered quotient/remainder with busy/done status.
interface divider_if #(
    parameter int M = 26,
    parameter int N = 14
);
    logic         en;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;

    modport master (
        output en, dividend, divisor,
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  en, dividend, divisor,
        output quotient, remainder, busy, done
    );
endinterface

// File: rtl/divider.sv
// Sequential unsigned restoring divider.
// Retires one quotient bit per clock, MSB first: M iteration cycles per
// division plus one cycle to publish the result. A start fires on a rising
// edge of en (en must be seen low before another start is accepted).
module divider #(
    parameter int M = 26,
    parameter int N = 14
) (
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_armed;
    logic [M-1:0]   r_work;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]   r_divisor;
    logic [N-1:0]   r_rem;        // partial remainder; always < divisor (or exact low bits for /0)
    logic [CW-1:0]  r_count;
    logic [M-1:0]   r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_busy;
    logic           r_done;

    logic [N:0]     w_shift;
    logic           w_ge;
    logic [N-1:0]   w_diff;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    // The full N+1-bit value decides the compare; the difference itself
    // always fits in N bits, so only the low bits are subtracted.
    assign w_shift = {r_rem, r_work[M-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = w_shift[N-1:0] - r_divisor;

    // Control FSM, datapath iteration and registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b1;
            r_work      <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!bus.en) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.en && r_armed) begin
                        r_work    <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_rem     <= '0;
                        r_count   <= CW'(M);
                        r_armed   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_rem   <= w_ge ? w_diff : w_shift[N-1:0];
                    r_work  <= {r_work[M-2:0], w_ge};
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_quotient  <= r_work;
                    r_remainder <= r_rem;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the sequential divider: a scoreboard queue holds
// expected quotient/remainder pairs pushed at start and popped on done.
module tb_divider;
    localparam int M = 26;
    localparam int N = 14;

    typedef struct packed {
        logic [M-1:0] q;
        logic [N-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_if #(.M(M), .N(N)) bus ();

    divider #(.M(M), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [M-1:0] a, input logic [N-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a[N-1:0];
        end else begin
            e.q = a / M'(b);
            e.r = N'(a % M'(b));
        end
        return e;
    endfunction

    // Scoreboard: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient",  32'(bus.quotient),  32'(mon_e.q));
                check("remainder", 32'(bus.remainder), 32'(mon_e.r));
            end
        end
    end

    // Count edges after the start edge until done; optionally disturb inputs mid-run.
    task automatic wait_done(input bit disturb, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= M + 10 && !found; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (i == 1) check("busy_run", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                found = 1'b1;
            end else if (disturb) begin
                if (i == 3) begin
                    bus.dividend = M'($urandom);
                    bus.divisor  = N'($urandom);
                    bus.en       = 1'b0;
                end
                if (i == 6) bus.en = 1'b1;
                if (i == 9) bus.en = 1'b0;
            end
        end
        if (!found) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic start(input logic [M-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.en       = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
    endtask

    task automatic run(input logic [M-1:0] a, input logic [N-1:0] b, input bit disturb);
        int n;
        start(a, b);
        wait_done(disturb, n);
        check("latency", 32'(n), 32'(M + 1));
        check("busy_after", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [M-1:0] a;
        logic [N-1:0] b;

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("rst_quotient",  32'(bus.quotient),  32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        #1 rst = 1'b0;

        // Fixed-point case, en raised at t=8 and held high.
        #5;
        bus.dividend = {12'h9D6, 14'b0};
        bus.divisor  = 14'h2D4B;
        bus.en       = 1'b1;
        sb.push_back(model(bus.dividend, bus.divisor));
        @(posedge clk);
        wait_done(1'b0, n);
        check("t1_latency",   32'(n), 32'(M + 1));
        check("t1_quotient",  32'(bus.quotient),  32'h0000DE5);
        check("t1_remainder", 32'(bus.remainder), 32'h2CE9);
        repeat (40) @(negedge clk);
        check("t1_single_done", 32'(n_done), 32'd1);
        check("t1_no_rerun",    32'(bus.busy), 32'd0);
        bus.en = 1'b0;

        // Small cases.
        run(M'(100), N'(7), 1'b0);
        run(M'(5),   N'(9), 1'b0);

        // Divide by zero with all-ones dividend.
        run('1, '0, 1'b0);
        check("div0_quotient",  32'(bus.quotient),  32'h3FFFFFF);
        check("div0_remainder", 32'(bus.remainder), 32'h3FFF);

        // Asynchronous reset mid-run, then a fresh division.
        start(M'(12345678), N'(321));
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_quotient",  32'(bus.quotient),  32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_done",      32'(bus.done),      32'd0);
        sb.delete();
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        run(M'(12345678), N'(321), 1'b0);

        // Operand and en changes while busy must be ignored.
        run(M'(1000000), N'(37), 1'b1);
        @(negedge clk);
        d0 = n_done;
        repeat (M + 5) @(negedge clk);
        check("no_restart_done", 32'(n_done), 32'(d0));
        check("no_restart_busy", 32'(bus.busy), 32'd0);

        // Boundary values.
        run('1, N'(1), 1'b0);
        run('1, '1, 1'b0);
        run('0, N'(123), 1'b0);
        run(M'(77), N'(1), 1'b0);

        // Randomised back-to-back runs.
        for (int i = 0; i < 20; i++) begin
            a = M'($urandom) >> $urandom_range(0, M - 1);
            b = (i % 7 == 3) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            run(a, b, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
